// File: rtl/wishbone_slave_regbank_pkg.sv
// Shared constants for the Wishbone register bank: FSM encodings and the
// word-alignment mask used by the address decoder.
package wishbone_slave_regbank_pkg;

    typedef logic [1:0] wb_state_t;

    localparam wb_state_t S_IDLE = 2'd0;
    localparam wb_state_t S_WAIT = 2'd1;
    localparam wb_state_t S_RESP = 2'd2;

    localparam logic [1:0] WB_ADR_ALIGN = 2'b00;

endpackage

// File: rtl/wishbone_slave_regbank_byte_merge.sv
// Byte-lane merge: each selected byte comes from the new word, the rest
// keep the old register contents.
module wb_byte_merge #(
    parameter int DWIDTH = 32,
    parameter int SWIDTH = 4
) (
    input  logic [DWIDTH-1:0] old_word,
    input  logic [DWIDTH-1:0] new_word,
    input  logic [SWIDTH-1:0] sel,
    output logic [DWIDTH-1:0] merged
);

    always_comb begin
        merged = old_word;
        for (int k = 0; k < SWIDTH; k++) begin
            if (sel[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/wishbone_slave_regbank.sv
// Classic Wishbone slave with NUM_REGS-1 read/write registers plus one
// read-only status word, programmable wait states and a write strobe.
module wishbone_slave_regbank
    import wishbone_slave_regbank_pkg::*;
#(
    parameter int WB_DWIDTH   = 32,
    parameter int WB_SWIDTH   = 4,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 1,
    parameter int IDX_W       = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          scan_in0,
    input  logic                          scan_in1,
    input  logic                          scan_in2,
    input  logic                          scan_in3,
    input  logic                          scan_in4,
    input  logic                          scan_enable,
    input  logic                          test_mode,
    output logic                          scan_out0,
    output logic                          scan_out1,
    output logic                          scan_out2,
    output logic                          scan_out3,
    output logic                          scan_out4,
    input  logic [31:0]                   i_wb_adr,
    input  logic [WB_SWIDTH-1:0]          i_wb_sel,
    input  logic                          i_wb_we,
    input  logic [WB_DWIDTH-1:0]          i_wb_dat,
    output logic [WB_DWIDTH-1:0]          o_wb_dat,
    input  logic                          i_wb_cyc,
    input  logic                          i_wb_stb,
    output logic                          o_wb_ack,
    output logic                          o_wb_err,
    input  logic [WB_DWIDTH-1:0]          i_status,
    output logic [NUM_REGS*WB_DWIDTH-1:0] o_regs,
    output logic                          o_wr_strobe,
    output logic [IDX_W-1:0]              o_wr_index
);

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_REGS - 1);

    wb_state_t            state;
    logic [3:0]           wait_cnt;
    logic [IDX_W-1:0]     req_idx;
    logic                 req_we;
    logic                 req_err;
    logic [WB_SWIDTH-1:0] req_sel;
    logic [WB_DWIDTH-1:0] req_dat;
    logic [WB_DWIDTH-1:0] regs [NUM_REGS-1];

    logic [13:0]          adr_word;
    logic                 adr_err;
    logic [WB_DWIDTH-1:0] rw_word;
    logic [WB_DWIDTH-1:0] rd_word;
    logic [WB_DWIDTH-1:0] merged_word;
    logic                 wr_fire;

    // Scan ports are stitched by the DFT flow; the functional netlist leaves them idle.
    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode, i_wb_adr[31:16]};

    assign adr_word = i_wb_adr[15:2];
    assign adr_err  = (i_wb_adr[1:0] != WB_ADR_ALIGN) || (adr_word >= 14'(NUM_REGS));

    always_comb begin
        rw_word = '0;
        for (int k = 0; k < NUM_REGS - 1; k++) begin
            if (req_idx == IDX_W'(k)) begin
                rw_word = regs[k];
            end
        end
        rd_word = (req_idx == TOP_IDX) ? i_status : rw_word;
    end

    wb_byte_merge #(
        .DWIDTH (WB_DWIDTH),
        .SWIDTH (WB_SWIDTH)
    ) u_merge (
        .old_word (rw_word),
        .new_word (req_dat),
        .sel      (req_sel),
        .merged   (merged_word)
    );

    assign wr_fire = (state == S_RESP) && req_we && !req_err && (req_idx != TOP_IDX);

    // Response outputs are registered off the RESP cycle, so ack lands
    // WAIT_STATES+1 edges after the request was sampled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            req_idx     <= '0;
            req_we      <= 1'b0;
            req_err     <= 1'b0;
            req_sel     <= '0;
            req_dat     <= '0;
            o_wb_ack    <= 1'b0;
            o_wb_err    <= 1'b0;
            o_wb_dat    <= '0;
            o_wr_strobe <= 1'b0;
            o_wr_index  <= '0;
            for (int k = 0; k < NUM_REGS - 1; k++) begin
                regs[k] <= '0;
            end
        end else begin
            o_wb_ack    <= 1'b0;
            o_wb_err    <= 1'b0;
            o_wb_dat    <= '0;
            o_wr_strobe <= 1'b0;
            o_wr_index  <= '0;
            case (state)
                S_IDLE: begin
                    if (i_wb_cyc && i_wb_stb) begin
                        req_idx  <= i_wb_adr[IDX_W+1:2];
                        req_we   <= i_wb_we;
                        req_err  <= adr_err;
                        req_sel  <= i_wb_sel;
                        req_dat  <= i_wb_dat;
                        wait_cnt <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
                        state    <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!i_wb_cyc) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state    <= S_IDLE;
                    o_wb_ack <= !req_err;
                    o_wb_err <= req_err;
                    if (!req_err && !req_we) begin
                        o_wb_dat <= rd_word;
                    end
                    if (wr_fire) begin
                        o_wr_strobe <= 1'b1;
                        o_wr_index  <= req_idx;
                        for (int k = 0; k < NUM_REGS - 1; k++) begin
                            if (req_idx == IDX_W'(k)) begin
                                regs[k] <= merged_word;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_regs = '0;
        for (int k = 0; k < NUM_REGS - 1; k++) begin
            o_regs[k*WB_DWIDTH +: WB_DWIDTH] = regs[k];
        end
    end

endmodule

// File: tb/tb_wishbone_slave_regbank.sv
// Directed bench: three instances with WAIT_STATES 1, 0 and 3 share the bus
// data lines, each with its own cyc/stb.
module tb_wishbone_slave_regbank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdat;
    logic [31:0] status;
    logic [2:0]  cyc;
    logic [2:0]  stb;
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [2:0]  wstb;
    logic [31:0] rdat   [3];
    logic [3:0]  widx   [3];
    logic [511:0] regs_o [3];
    logic [14:0] scan_o;

    int n_checks = 0;
    int n_pass   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wishbone_slave_regbank #(
            .WB_DWIDTH   (32),
            .WB_SWIDTH   (4),
            .NUM_REGS    (16),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
            .IDX_W       (4)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .scan_in0    (1'b0),
            .scan_in1    (1'b0),
            .scan_in2    (1'b0),
            .scan_in3    (1'b0),
            .scan_in4    (1'b0),
            .scan_enable (1'b0),
            .test_mode   (1'b0),
            .scan_out0   (scan_o[g*5+0]),
            .scan_out1   (scan_o[g*5+1]),
            .scan_out2   (scan_o[g*5+2]),
            .scan_out3   (scan_o[g*5+3]),
            .scan_out4   (scan_o[g*5+4]),
            .i_wb_adr    (adr),
            .i_wb_sel    (sel),
            .i_wb_we     (we),
            .i_wb_dat    (wdat),
            .o_wb_dat    (rdat[g]),
            .i_wb_cyc    (cyc[g]),
            .i_wb_stb    (stb[g]),
            .o_wb_ack    (ack[g]),
            .o_wb_err    (err[g]),
            .i_status    (status),
            .o_regs      (regs_o[g]),
            .o_wr_strobe (wstb[g]),
            .o_wr_index  (widx[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] wd, output logic [31:0] rd, output logic ak,
                        output logic er, output int lat, output int nstb,
                        output logic [3:0] lidx);
        adr = a; we = w; sel = s; wdat = wd;
        cyc[d] = 1'b1; stb[d] = 1'b1;
        rd = '0; ak = 1'b0; er = 1'b0; lat = -1; nstb = 0; lidx = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (wstb[d]) begin
                nstb++;
                lidx = widx[d];
            end
            if (ack[d] || err[d]) begin
                ak = ack[d]; er = err[d]; rd = rdat[d]; lat = n - 1;
                break;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        if (lat < 0) check("response_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (wstb[d]) nstb++;
        check("resp_width_one", {31'b0, ack[d] | err[d]}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        ak, er, seen;
    int          lat, ns;
    logic [3:0]  li;

    initial begin
        reset = 1'b0; cyc = '0; stb = '0; adr = '0; sel = '0; we = 1'b0;
        wdat = '0; status = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, ack[0]}, 32'd0);
        check("rst_err", {31'b0, err[0]}, 32'd0);
        check("rst_dat", rdat[0], 32'd0);
        check("rst_strobe_idx", {27'b0, wstb[0], widx[0]}, 32'd0);
        check("rst_regs_or", {31'b0, |regs_o[0]}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset mid-WAIT: reg 3 holds a value, a second write is cut short.
        xfer(0, 32'h0C, 1'b1, 4'hF, 32'h12345678, rd, ak, er, lat, ns, li);
        check("pre_reset_reg3", regs_o[0][3*32 +: 32], 32'h12345678);
        adr = 32'h0C; we = 1'b1; sel = 4'hF; wdat = 32'hCAFEF00D;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst_wait_ack_err", {30'b0, ack[0], err[0]}, 32'd0);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        xfer(0, 32'h0C, 1'b0, 4'hF, 32'h0, rd, ak, er, lat, ns, li);
        check("post_reset_reg3", rd, 32'h00000000);

        // Reset while ack is high drops it without waiting for a clock.
        adr = 32'h0; we = 1'b0; cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk); #1;
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(posedge clk); #1;
        check("ack_before_reset", {31'b0, ack[1]}, 32'd1);
        reset = 1'b0;
        #1;
        check("ack_dropped_async", {31'b0, ack[1]}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Byte-select merge into reg 2.
        xfer(0, 32'h08, 1'b1, 4'hF, 32'h11223344, rd, ak, er, lat, ns, li);
        check("wr1_strobe_cnt", ns, 32'd1);
        check("wr1_index", {28'b0, li}, 32'd2);
        xfer(0, 32'h08, 1'b1, 4'b0101, 32'hAABBCCDD, rd, ak, er, lat, ns, li);
        check("wr2_strobe_cnt", ns, 32'd1);
        check("wr2_index", {28'b0, li}, 32'd2);
        xfer(0, 32'h08, 1'b0, 4'h0, 32'h0, rd, ak, er, lat, ns, li);
        check("rd_reg2_merged", rd, 32'h11BB33DD);
        check("rd_reg2_ack", {30'b0, ak, er}, 32'd2);
        check("oregs_reg2", regs_o[0][2*32 +: 32], 32'h11BB33DD);

        // sel=0 write: strobe still fires, no bytes change.
        xfer(0, 32'h08, 1'b1, 4'h0, 32'hFFFFFFFF, rd, ak, er, lat, ns, li);
        check("sel0_strobe_cnt", ns, 32'd1);
        check("sel0_reg2", regs_o[0][2*32 +: 32], 32'h11BB33DD);

        // Latency per wait-state setting.
        xfer(1, 32'h00, 1'b0, 4'hF, 32'h0, rd, ak, er, lat, ns, li);
        check("lat_ws0", lat, 32'd1);
        xfer(0, 32'h00, 1'b0, 4'hF, 32'h0, rd, ak, er, lat, ns, li);
        check("lat_ws1", lat, 32'd2);
        xfer(2, 32'h00, 1'b0, 4'hF, 32'h0, rd, ak, er, lat, ns, li);
        check("lat_ws3", lat, 32'd4);
        check("lat_ws3_ack", {30'b0, ak, er}, 32'd2);

        // Error decodes: misaligned and out-of-range, both aliasing idx 0.
        xfer(0, 32'h42, 1'b1, 4'hF, 32'hFFFFFFFF, rd, ak, er, lat, ns, li);
        check("err_misalign_flags", {30'b0, ak, er}, 32'd1);
        check("err_misalign_dat", rd, 32'd0);
        check("err_misalign_strobe", ns, 32'd0);
        xfer(0, 32'h40, 1'b1, 4'hF, 32'hFFFFFFFF, rd, ak, er, lat, ns, li);
        check("err_range_flags", {30'b0, ak, er}, 32'd1);
        check("err_range_dat", rd, 32'd0);
        check("err_range_strobe", ns, 32'd0);
        check("err_reg0_intact", regs_o[0][31:0], 32'd0);
        xfer(0, 32'h40, 1'b0, 4'hF, 32'h0, rd, ak, er, lat, ns, li);
        check("err_read_dat", rd, 32'd0);

        // Status word at the top index.
        status = 32'hDEADBEEF;
        xfer(0, 32'h3C, 1'b0, 4'hF, 32'h0, rd, ak, er, lat, ns, li);
        check("status_read", rd, 32'hDEADBEEF);
        xfer(0, 32'h3C, 1'b1, 4'hF, 32'h0, rd, ak, er, lat, ns, li);
        check("status_wr_ack", {30'b0, ak, er}, 32'd2);
        check("status_wr_nostrobe", ns, 32'd0);
        xfer(0, 32'h3C, 1'b0, 4'hF, 32'h0, rd, ak, er, lat, ns, li);
        check("status_reread", rd, 32'hDEADBEEF);
        check("oregs_top_zero", regs_o[0][15*32 +: 32], 32'd0);

        // Abort: cyc drops during WAIT of a write to reg 1.
        xfer(0, 32'h04, 1'b1, 4'hF, 32'h5, rd, ak, er, lat, ns, li);
        adr = 32'h04; we = 1'b1; sel = 4'hF; wdat = 32'hFFFFFFFF;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        @(posedge clk); #1;
        cyc[0] = 1'b0; stb[0] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (ack[0] || err[0] || wstb[0]) seen = 1'b1;
        end
        check("abort_no_response", {31'b0, seen}, 32'd0);
        xfer(0, 32'h04, 1'b0, 4'hF, 32'h0, rd, ak, er, lat, ns, li);
        check("abort_reg1_kept", rd, 32'h5);
        check("abort_next_ack", {30'b0, ak, er}, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
